// File: rtl/gclk_ctrl_pkg.sv
// Shared types and default timing constants for the gclk_ctrl clock-gating
// controller.
package gclk_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } gclk_state_t;

  localparam int unsigned DEF_N_DOM       = 4;
  localparam int unsigned DEF_WAKE_CYCLES = 2;
  localparam int unsigned DEF_IDLE_CYCLES = 8;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: a low-transparent latch on the enable followed by an
// AND with the clock. The latch has an asynchronous clear so the gated clock
// drops at once when rst rises, even in the middle of a high phase.
// Ports:
//   clk  - source clock
//   rst  - asynchronous active-high clear of the enable latch
//   en   - registered enable (must come from a flop on clk's rising edge)
//   gclk - gated clock output
module clk_gate_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);

  logic en_l;

  // Closed while clk is high, so en changing after the rising edge cannot
  // shorten or create a pulse in the current high phase.
  always_latch begin
    if (rst)
      en_l <= 1'b0;
    else if (!clk)
      en_l <= en;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/gclk_ctrl.sv
// Per-domain clock-gating controller. Each domain runs an OFF/WAKE/ON/IDLE
// FSM; a round-robin arbiter admits at most one domain into WAKE at a time
// to limit inrush. A registered enable per domain drives one clk_gate_cell.
// Ports:
//   sysclk   - system clock, all state updates on its rising edge
//   rst      - asynchronous active-high reset
//   req      - level request per domain
//   force_on - bypass: every domain clocked and acknowledged
//   ack      - domain clock running and stable (registered)
//   gclk     - gated clock per domain
//   waking   - some domain is in WAKE (registered)
//   stat_sel - statistics domain select      (GCLK_STATS_EN only)
//   stat_cnt - gated-off cycles of stat_sel  (GCLK_STATS_EN only)
// Build option: define GCLK_STATS_EN to add per-domain saturating
// gated-off cycle counters.
module gclk_ctrl
  import gclk_ctrl_pkg::*;
#(
  parameter  int unsigned N_DOM       = DEF_N_DOM,
  parameter  int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter  int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter  int unsigned CNT_W       = DEF_CNT_W,
  localparam int unsigned SEL_W       = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [N_DOM-1:0] req,
  input  logic             force_on,
  output logic [N_DOM-1:0] ack,
  output logic [N_DOM-1:0] gclk,
  output logic             waking
`ifdef GCLK_STATS_EN
  ,
  input  logic [SEL_W-1:0] stat_sel,
  output logic [CNT_W-1:0] stat_cnt
`endif
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_DOM - 1);

  gclk_state_t      st_q  [N_DOM];
  gclk_state_t      st_d  [N_DOM];
  logic [CNT_W-1:0] tmr_q [N_DOM];
  logic [CNT_W-1:0] tmr_d [N_DOM];
  logic [SEL_W-1:0] rr_q;
  logic [N_DOM-1:0] en_q;

  logic             any_wake;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] idx;
  logic [N_DOM-1:0] grant;
  logic [N_DOM-1:0] en_d;
  logic [N_DOM-1:0] ack_d;
  logic             wake_d;

  // Wake arbiter: looks only at registered states, so a grant can never be
  // issued on the same edge a previous WAKE ends.
  always_comb begin
    any_wake  = 1'b0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = '0;
    for (int unsigned i = 0; i < N_DOM; i++)
      if (st_q[i] == WAKE) any_wake = 1'b1;
    if (!any_wake) begin
      for (int unsigned k = 0; k < N_DOM; k++) begin
        idx = SEL_W'((32'(rr_q) + k) % N_DOM);
        if (!grant_vld && req[idx] && st_q[idx] == OFF) begin
          grant_vld  = 1'b1;
          grant_idx  = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  // Per-domain next state; one timer per domain serves both WAKE and IDLE.
  always_comb begin
    wake_d = 1'b0;
    en_d   = '0;
    ack_d  = '0;
    for (int unsigned i = 0; i < N_DOM; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      case (st_q[i])
        OFF: begin
          if (grant[i]) begin
            st_d[i]  = WAKE;
            tmr_d[i] = WAKE_LOAD;
          end
        end
        WAKE: begin
          if (tmr_q[i] == '0) st_d[i] = ON;
          else                tmr_d[i] = tmr_q[i] - 1'b1;
        end
        ON: begin
          if (!req[i]) begin
            st_d[i]  = IDLE;
            tmr_d[i] = IDLE_LOAD;
          end
        end
        IDLE: begin
          if (req[i])               st_d[i] = ON;
          else if (tmr_q[i] == '0)  st_d[i] = OFF;
          else                      tmr_d[i] = tmr_q[i] - 1'b1;
        end
        default: st_d[i] = OFF;
      endcase
      en_d[i]  = (st_d[i] != OFF);
      ack_d[i] = (st_d[i] == ON) || (st_d[i] == IDLE);
      if (st_d[i] == WAKE) wake_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_DOM; i++) begin
        st_q[i]  <= OFF;
        tmr_q[i] <= '0;
      end
      rr_q   <= '0;
      en_q   <= '0;
      ack    <= '0;
      waking <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_DOM; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      if (grant_vld)
        rr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      en_q   <= en_d  | {N_DOM{force_on}};
      ack    <= ack_d | {N_DOM{force_on}};
      waking <= wake_d;
    end
  end

  for (genvar g = 0; g < N_DOM; g++) begin : g_gate
    clk_gate_cell u_gate (
      .clk  (sysclk),
      .rst  (rst),
      .en   (en_q[g]),
      .gclk (gclk[g])
    );
  end

`ifdef GCLK_STATS_EN
  logic [CNT_W-1:0] off_cnt [N_DOM];

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_DOM; i++) off_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_DOM; i++)
        if (st_q[i] == OFF && !force_on && off_cnt[i] != '1)
          off_cnt[i] <= off_cnt[i] + 1'b1;
    end
  end

  assign stat_cnt = (32'(stat_sel) < N_DOM) ? off_cnt[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_gclk_ctrl.sv
// Scoreboard bench for gclk_ctrl: the stimulus process pushes expected
// per-edge values of ack/gclk/waking (plus captured one-off samples); the
// monitor process pops and compares them #1 after each rising sysclk edge.
module tb_gclk_ctrl;

  typedef struct {
    int unsigned e;
    logic [3:0]  ack;
    logic [3:0]  gclk;
    logic        waking;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } cap_t;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       force_on;
  logic [3:0] ack;
  logic [3:0] gclk;
  logic       waking;

  exp_t        sb_q[$];
  cap_t        cap_q[$];
  int unsigned edge_n = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned g0_cnt = 0;
  bit          done = 1'b0;

  always #5 sysclk = ~sysclk;

  gclk_ctrl #(.N_DOM(4), .WAKE_CYCLES(2), .IDLE_CYCLES(8), .CNT_W(16)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .req      (req),
    .force_on (force_on),
    .ack      (ack),
    .gclk     (gclk),
    .waking   (waking)
`ifdef GCLK_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
`endif
  );

`ifdef GCLK_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;
  logic [1:0]  sel4 = 2'd0;
  logic [3:0]  req4 = 4'd0;
  logic [3:0]  ack4, gclk4;
  logic        waking4;
  logic [3:0]  stat_cnt4;
  logic        force4 = 1'b0;

  gclk_ctrl #(.N_DOM(4), .WAKE_CYCLES(2), .IDLE_CYCLES(8), .CNT_W(4)) dut4 (
    .sysclk   (sysclk),
    .rst      (rst),
    .req      (req4),
    .force_on (force4),
    .ack      (ack4),
    .gclk     (gclk4),
    .waking   (waking4),
    .stat_sel (sel4),
    .stat_cnt (stat_cnt4)
  );
`endif

  always @(posedge gclk[0]) g0_cnt <= g0_cnt + 1;

  task automatic expect_at(input int unsigned e, input logic [3:0] a,
                           input logic [3:0] g, input logic w, input string nm);
    exp_t x;
    x.e = e; x.ack = a; x.gclk = g; x.waking = w; x.name = nm;
    sb_q.push_back(x);
  endtask

  task automatic push_cap(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cap_t c;
    c.name = nm; c.act = act; c.exp = exp;
    cap_q.push_back(c);
  endtask

  // Returns at the falling edge just before rising edge number e.
  task automatic at_edge(input int unsigned e);
    while (edge_n + 1 < e) @(negedge sysclk);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst = 1'b1; req = '0; force_on = 1'b0;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
  endtask

  // Stimulus
  initial begin
    int unsigned t, u, v, f, base;
    rst = 1'b1; req = '0; force_on = 1'b0;
`ifdef GCLK_STATS_EN
    stat_sel = '0;
`endif
    repeat (3) @(negedge sysclk);
    rst = 1'b0;

    // Single domain wake, idle timeout, gclk edge count
    t = edge_n + 2;
    at_edge(t);
    base = g0_cnt;
    req = 4'b0001;
    expect_at(t,      4'b0000, 4'b0000, 1'b1, "d0_grant");
    expect_at(t + 1,  4'b0000, 4'b0001, 1'b1, "d0_first_gclk");
    expect_at(t + 2,  4'b0001, 4'b0001, 1'b0, "d0_ack");
    expect_at(t + 17, 4'b0001, 4'b0001, 1'b0, "d0_idle_hold");
    expect_at(t + 18, 4'b0000, 4'b0001, 1'b0, "d0_off_last_gclk");
    expect_at(t + 19, 4'b0000, 4'b0000, 1'b0, "d0_gclk_stopped");
    at_edge(t + 10);
    req = 4'b0000;
    at_edge(t + 26);
    push_cap("d0_gclk_edges", 32'(g0_cnt - base), 32'd18);

    // All four at once: serialized wakes
    do_reset();
    t = edge_n + 2;
    at_edge(t);
    req = 4'b1111;
    expect_at(t,      4'b0000, 4'b0000, 1'b1, "rr_g0");
    expect_at(t + 1,  4'b0000, 4'b0001, 1'b1, "rr_w0");
    expect_at(t + 2,  4'b0001, 4'b0001, 1'b0, "rr_a0");
    expect_at(t + 3,  4'b0001, 4'b0001, 1'b1, "rr_g1");
    expect_at(t + 4,  4'b0001, 4'b0011, 1'b1, "rr_w1");
    expect_at(t + 5,  4'b0011, 4'b0011, 1'b0, "rr_a1");
    expect_at(t + 6,  4'b0011, 4'b0011, 1'b1, "rr_g2");
    expect_at(t + 7,  4'b0011, 4'b0111, 1'b1, "rr_w2");
    expect_at(t + 8,  4'b0111, 4'b0111, 1'b0, "rr_a2");
    expect_at(t + 9,  4'b0111, 4'b0111, 1'b1, "rr_g3");
    expect_at(t + 10, 4'b0111, 4'b1111, 1'b1, "rr_w3");
    expect_at(t + 11, 4'b1111, 4'b1111, 1'b0, "rr_a3");
    expect_at(t + 12, 4'b1111, 4'b1111, 1'b0, "rr_all_on");

    // Domain 2 IDLE re-request, then rr check (still 0 -> domain 1 first)
    u = t + 14;
    at_edge(u);
    req = 4'b1011;
    expect_at(u,     4'b1111, 4'b1111, 1'b0, "d2_idle");
    expect_at(u + 5, 4'b1111, 4'b1111, 1'b0, "d2_reon");
    expect_at(u + 9, 4'b1111, 4'b1111, 1'b0, "d2_no_timeout");
    at_edge(u + 5);
    req = 4'b1111;
    v = u + 12;
    at_edge(v);
    req = 4'b0101;
    expect_at(v + 7,  4'b1111, 4'b1111, 1'b0, "d13_idle_hold");
    expect_at(v + 8,  4'b0101, 4'b1111, 1'b0, "d13_off");
    expect_at(v + 9,  4'b0101, 4'b0101, 1'b0, "d13_gclk_off");
    expect_at(v + 10, 4'b0101, 4'b0101, 1'b1, "rr_keep_g1");
    expect_at(v + 11, 4'b0101, 4'b0111, 1'b1, "rr_keep_w1");
    expect_at(v + 12, 4'b0111, 4'b0111, 1'b0, "rr_keep_a1");
    expect_at(v + 13, 4'b0111, 4'b0111, 1'b1, "rr_keep_g3");
    expect_at(v + 15, 4'b1111, 4'b1111, 1'b0, "rr_keep_a3");
    at_edge(v + 10);
    req = 4'b1111;

    // Asynchronous reset in the high phase during WAKE of domain 1
    at_edge(v + 17);
    do_reset();
    t = edge_n + 2;
    at_edge(t);
    req = 4'b0010;
    expect_at(t,     4'b0000, 4'b0000, 1'b1, "d1_grant");
    expect_at(t + 1, 4'b0000, 4'b0010, 1'b1, "d1_waking");
    at_edge(t + 1);
    @(posedge sysclk);
    #3;
    push_cap("gclk_before_rst", 32'(gclk), 32'h2);
    rst = 1'b1; req = '0;
    #1;
    push_cap("gclk_async_clr", 32'(gclk), 32'h0);
    push_cap("waking_async_clr", 32'(waking), 32'h0);
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    t = edge_n + 2;
    at_edge(t);
    req = 4'b1000;
    expect_at(t,     4'b0000, 4'b0000, 1'b1, "d3_grant");
    expect_at(t + 1, 4'b0000, 4'b1000, 1'b1, "d3_first_gclk");
    expect_at(t + 2, 4'b1000, 4'b1000, 1'b0, "d3_ack");

    // force_on bypass
    at_edge(t + 4);
    do_reset();
    f = edge_n + 2;
    at_edge(f);
    force_on = 1'b1;
    expect_at(f,     4'b1111, 4'b0000, 1'b0, "force_ack");
    expect_at(f + 1, 4'b1111, 4'b1111, 1'b0, "force_gclk");
    expect_at(f + 2, 4'b1111, 4'b1111, 1'b0, "force_hold");
    expect_at(f + 3, 4'b0000, 4'b1111, 1'b0, "force_rel_ack");
    expect_at(f + 4, 4'b0000, 4'b0000, 1'b0, "force_rel_gclk");
    at_edge(f + 3);
    force_on = 1'b0;

`ifdef GCLK_STATS_EN
    at_edge(f + 6);
    do_reset();
    f = edge_n;
    at_edge(f + 20);
    req = 4'b0001;
    at_edge(f + 22);
    stat_sel = 2'd0;
    #1;
    push_cap("stat_d0_off20", 32'(stat_cnt), 32'd20);
    stat_sel = 2'd1;
    #1;
    push_cap("stat_d1_off21", 32'(stat_cnt), 32'd21);
    push_cap("stat_sat_w4", 32'(stat_cnt4), 32'd15);
`endif

    req = '0;
    done = 1'b1;
  end

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    int unsigned drain = 0;
    exp_t x;
    cap_t c;
    forever begin
      @(posedge sysclk);
      #1;
      edge_n++;
      while (cap_q.size() > 0) begin
        c = cap_q.pop_front();
        compare(c.name, c.act, c.exp);
      end
      while (sb_q.size() > 0 && sb_q[0].e <= edge_n) begin
        x = sb_q.pop_front();
        if (x.e < edge_n) begin
          compare({x.name, "_missed"}, 32'(edge_n), 32'(x.e));
        end else begin
          compare({x.name, "_ack"},    32'(ack),    32'(x.ack));
          compare({x.name, "_gclk"},   32'(gclk),   32'(x.gclk));
          compare({x.name, "_waking"}, 32'(waking), 32'(x.waking));
        end
      end
      if (done) begin
        drain++;
        if ((sb_q.size() == 0 && cap_q.size() == 0) || drain > 40) break;
      end
    end
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      compare({x.name, "_never_reached"}, 32'(edge_n), 32'(x.e));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/gclk_ctrl.md
# gclk_ctrl

Per-domain clock-gating controller for designs with multiple DFF banks on gated branches of `sysclk`. Each domain raises a level request. The block wakes domains one at a time through a round-robin wake arbiter, which limits inrush. It drives a glitch-free latch-based gated clock per domain, acknowledges when the clock is stable, and gates the domain off after a programmable idle timeout. It sits between the system clock root and the gated DFF banks, and a gate-level simulator must resolve its outputs as true clock edges.

## Interface
- `N_DOM`, 4: number of gated clock domains
- `WAKE_CYCLES`, 2: cycles a domain spends in WAKE before ack (≥1)
- `IDLE_CYCLES`, 8: cycles without request before gating off (≥1)
- `CNT_W`, 16: width of timers and statistics counters
- `sysclk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N_DOM  level request per domain, sampled at rising edge of `sysclk`
- `force_on`  in  1  test bypass: all domains clocked and acked
- `ack`  out  N_DOM  domain clock running and stable (registered)
- `gclk`  out  N_DOM  gated clock per domain
- `waking`  out  1  some domain is in WAKE (registered)
- `stat_sel`  in  $clog2(N_DOM)  statistics domain select (only with `GCLK_STATS_EN`)
- `stat_cnt`  out  CNT_W  gated-off cycle count of the selected domain (only with `GCLK_STATS_EN`)

## Operation
- Each domain has its own FSM with states OFF, WAKE, ON, IDLE. The FSM drives the registered enable `en_q[i]`:
  - OFF: `en_q` = 0.
  - WAKE, ON, IDLE: `en_q` = 1.
- Transitions:
  - OFF→WAKE: `req[i]`=1 and domain i holds the wake grant. The wake timer loads WAKE_CYCLES-1.
  - WAKE→ON: when the wake timer reaches 0. WAKE is non-abortable, so dropping `req` during WAKE has no effect until ON.
  - ON→IDLE: `req[i]`=0. The idle timer loads IDLE_CYCLES-1.
  - IDLE→ON: `req[i]`=1. No re-wake and no arbitration.
  - IDLE→OFF: idle timer reaches 0 with `req[i]`=0. If `req` is 1 on that same edge, the domain goes to ON instead.
- `ack[i]` is registered and equals (next state ∈ {ON, IDLE}) | `force_on`.
- Wake arbiter:
  - A grant is issued only on an edge where no domain is in WAKE (registered state).
  - At most one domain enters WAKE per edge.
  - Round-robin over OFF domains with `req`=1, starting at pointer `rr`.
  - `rr` resets to 0 and becomes granted index + 1 (mod N_DOM) on each grant.
- `force_on` is registered into `en_q` as OR with the FSM enable. FSMs keep running underneath.
- Gate cell: a latch, transparent while `sysclk` is low, captures `en_q`. Then `gclk` = `sysclk` & latch. Resulting rules:
  - No runt pulses.
  - No combinational path from `req` to `gclk`.
- Reset (asynchronous, any time, including mid-WAKE):
  - All FSMs go to OFF; `en_q`, `ack`, `waking` = 0; `rr` = 0; timers = 0.
  - The gate latch clears asynchronously, so `gclk` = 0 immediately, even while `sysclk` is high.

## Timing
- Grant on edge t:
  - `en_q` = 1 after edge t.
  - First `gclk` rising edge coincides with `sysclk` edge t+1.
  - `ack` = 1 after edge t+WAKE_CYCLES.
- `req` low sampled at edge u in ON:
  - `ack` and `en_q` drop after edge u+IDLE_CYCLES.
  - The last `gclk` rising edge is at u+IDLE_CYCLES.
- Back-to-back wakes: the next grant is on edge t+WAKE_CYCLES+1 at the earliest.
- `force_on` rising at edge f: `ack` = all-ones after edge f, and `gclk` runs from edge f+1.

## Configuration
- `GCLK_STATS_EN` defined:
  - Per-domain CNT_W saturating counter, incremented each cycle the domain is OFF and `force_on`=0.
  - Cleared by reset.
  - Read combinationally via `stat_sel`/`stat_cnt`.
- Undefined: counters, `stat_sel` and `stat_cnt` are absent, and the remaining behaviour is identical.

## Structure
- Package `gclk_ctrl_pkg`:
  - `gclk_state_t` enum (OFF, WAKE, ON, IDLE)
  - default timing constants
- Sub-module `clk_gate_cell`: latch plus AND with asynchronous clear. Instantiated N_DOM times so that gate-level simulation sees one recognisable gating primitive per domain.

## Test plan
All scenarios use the parameter defaults (N_DOM=4, WAKE=2, IDLE=8).
- `req`=0001 from edge 0:
  - `en_q[0]` high after edge 0, first `gclk[0]` edge at 1, `ack` = 0001 after edge 2.
  - Drop `req` at edge 10 → `ack` = 0000 after edge 18.
  - Exactly 18 `gclk[0]` rising edges.
- `req` = 1111 at once → grants 0,1,2,3 at edges 0,3,6,9; `ack` bits rise after edges 2,5,8,11; `waking` never covers two domains.
- Domain 2 in IDLE with timer 3, `req[2]` re-raised → ON next edge, `ack[2]` stays 1, no WAKE entry, `rr` unchanged.
- `rst` pulse mid-cycle while `sysclk` is high during WAKE of domain 1:
  - `gclk` = 0000 immediately; `ack` = 0000 and `rr` = 0 after reset.
  - Re-request of domain 3 is granted first.
- `force_on`=1 with `req`=0 → `ack` = 1111 after the next edge, all `gclk` follow `sysclk` from the following edge; deassert → `ack` = 0000, clocks stop.
- With `GCLK_STATS_EN`: domain 0 OFF 20 cycles then woken → `stat_sel`=0 gives `stat_cnt`=20; counter saturates at 2^CNT_W-1 with CNT_W=4 (reads 15).
